// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between a fill sequencer (port 0)
// and a readback engine (port 1), with bounded bursts and tagged read returns.
module bram_port_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we0,
   input  logic              we1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   // One-hot encoding: the state bits are the registered grants.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] G0   = 2'b01;
   localparam logic [1:0] G1   = 2'b10;

   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
   logic             last_served, last_d;
   logic             acc0, acc1;
   logic             own_req, oth_req, own_id;
   logic [1:0]       oth_state;

   assign gnt0 = state[0];
   assign gnt1 = state[1];

   assign acc0 = gnt0 & req0;
   assign acc1 = gnt1 & req1;

   assign bram_en   = acc0 | acc1;
   assign bram_addr = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
   assign bram_we   = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
   assign bram_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
   assign rdata     = bram_dout;

   // Requests seen from the point of view of whichever port holds the grant.
   assign own_req   = gnt0 ? req0 : req1;
   assign oth_req   = gnt0 ? req1 : req0;
   assign own_id    = gnt1;
   assign oth_state = gnt0 ? G1 : G0;
   assign cnt_inc   = cnt + 1'b1;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      last_d  = last_served;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (req0 && req1) state_d = last_served ? G0 : G1;
            else if (req0)    state_d = G0;
            else if (req1)    state_d = G1;
         end
         G0, G1: begin
            if (own_req) begin
               if (cnt_inc == MAX_CNT) begin
                  cnt_d = '0;
                  if (oth_req) begin
                     state_d = oth_state;
                     last_d  = own_id;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               cnt_d   = '0;
               last_d  = own_id;
               state_d = oth_req ? oth_state : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         last_served <= last_d;
         // Tagged by issuer, so a read on the final cycle of a grant still returns correctly.
         rvalid0     <= acc0 & ~we0;
         rvalid1     <= acc1 & ~we1;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: per-port op queues drive requesters,
// a grant-rule model plus a memory model predict port activity and read data.
module tb_bram_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int MB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata, bram_din;
   logic [AW-1:0] bram_addr;
   logic          bram_en, bram_we;
   logic [DW-1:0] bram_dout = '0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   // Behavioural BRAM with one-cycle read latency.
   logic [DW-1:0] bram_mem [0:65535];
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) bram_mem[bram_addr] <= bram_din;
         else         bram_dout <= bram_mem[bram_addr];
      end
   end

   typedef struct {
      logic          v;
      logic [AW-1:0] a;
      logic          w;
      logic [DW-1:0] d;
   } op_t;

   op_t           drv_q0[$], drv_q1[$];
   op_t           cur0, cur1;
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   logic [DW-1:0] exp_mem [0:65535];

   bit acc0_f = 0, acc1_f = 0, mon_on = 0;
   int acc_cnt0 = 0, acc_cnt1 = 0;
   int m_owner = -1, m_served = 0, m_last = 1;
   int n_checks = 0, n_fail = 0;

   function automatic logic [DW-1:0] seed_val(int a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic op_t mk(logic v, logic [AW-1:0] a, logic w, logic [DW-1:0] d);
      op_t o;
      o.v = v; o.a = a; o.w = w; o.d = d;
      return o;
   endfunction

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endfunction

   // Driver: a presented op is held until accepted; idle entries last one cycle.
   task automatic drive();
      if (!cur0.v || acc0_f) cur0 = (drv_q0.size() != 0) ? drv_q0.pop_front() : mk(0, '0, 0, '0);
      if (!cur1.v || acc1_f) cur1 = (drv_q1.size() != 0) ? drv_q1.pop_front() : mk(0, '0, 0, '0);
      req0 = cur0.v; addr0 = cur0.v ? cur0.a : '0; we0 = cur0.v & cur0.w; wdata0 = cur0.v ? cur0.d : '0;
      req1 = cur1.v; addr1 = cur1.v ? cur1.a : '0; we1 = cur1.v & cur1.w; wdata1 = cur1.v ? cur1.d : '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit all_idle();
      return drv_q0.size() == 0 && drv_q1.size() == 0 && !cur0.v && !cur1.v &&
             exp_q0.size() == 0 && exp_q1.size() == 0;
   endfunction

   task automatic run_idle(int budget);
      int c = 0;
      while (!all_idle() && c < budget) begin
         step();
         c++;
      end
      check("drain", 32'(all_idle()), 32'd1);
      step();
      step();
   endtask

   // Monitor and scoreboard, sampling on the falling edge.
   always @(negedge clk) begin
      bit            a0, a1, ro, rt;
      int            o;
      logic [AW-1:0] ea;
      logic          ew;
      logic [DW-1:0] ed, ev;
      if (mon_on) begin
         check("gnt0", 32'(gnt0), 32'(m_owner == 0));
         check("gnt1", 32'(gnt1), 32'(m_owner == 1));
         a0 = (m_owner == 0) && req0;
         a1 = (m_owner == 1) && req1;
         check("bram_en", 32'(bram_en), 32'(a0 | a1));
         if (m_owner == 0)      begin ea = addr0; ew = we0; ed = wdata0; end
         else if (m_owner == 1) begin ea = addr1; ew = we1; ed = wdata1; end
         else                   begin ea = '0;    ew = 1'b0; ed = '0;    end
         check("bram_addr", 32'(bram_addr), 32'(ea));
         check("bram_we", 32'(bram_we), 32'(ew));
         check("bram_din", bram_din, ed);

         check("rvalid0", 32'(rvalid0), 32'(exp_q0.size() != 0));
         if (exp_q0.size() != 0) begin
            ev = exp_q0.pop_front();
            if (rvalid0) check("rdata0", rdata, ev);
         end
         check("rvalid1", 32'(rvalid1), 32'(exp_q1.size() != 0));
         if (exp_q1.size() != 0) begin
            ev = exp_q1.pop_front();
            if (rvalid1) check("rdata1", rdata, ev);
         end

         acc0_f = a0;
         acc1_f = a1;
         if (a0) begin
            acc_cnt0++;
            if (we0) exp_mem[addr0] = wdata0;
            else if (!rst) exp_q0.push_back(exp_mem[addr0]);
         end
         if (a1) begin
            acc_cnt1++;
            if (we1) exp_mem[addr1] = wdata1;
            else if (!rst) exp_q1.push_back(exp_mem[addr1]);
         end

         // Grant rules: fair tie-break, burst limit, release on idle request.
         if (rst) begin
            m_owner = -1; m_served = 0; m_last = 1;
            exp_q0.delete();
            exp_q1.delete();
         end else if (m_owner < 0) begin
            if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
            m_served = 0;
         end else begin
            o  = m_owner;
            ro = (o == 0) ? req0 : req1;
            rt = (o == 0) ? req1 : req0;
            if (ro) begin
               m_served++;
               if (m_served == MB) begin
                  m_served = 0;
                  if (rt) begin m_last = o; m_owner = 1 - o; end
               end
            end else begin
               m_last   = o;
               m_served = 0;
               m_owner  = rt ? 1 - o : -1;
            end
         end
      end
   end

   initial begin
      int base, guard;
      for (int i = 0; i < 65536; i++) begin
         bram_mem[i] = seed_val(i);
         exp_mem[i]  = seed_val(i);
      end
      cur0 = mk(0, '0, 0, '0);
      cur1 = mk(0, '0, 0, '0);
      drive();
      rst = 1'b1;
      step();
      mon_on = 1;
      step();
      step();
      rst = 1'b0;

      // Port 0 alone, four reads.
      for (int i = 0; i < 4; i++) drv_q0.push_back(mk(1, 16'(i), 0, '0));
      run_idle(100);

      // Both ports from reset, long read streams alternate in bursts.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drv_q0.push_back(mk(1, 16'($urandom_range(0, 63)), 0, '0));
         drv_q1.push_back(mk(1, 16'($urandom_range(0, 63)), 0, '0));
      end
      run_idle(300);

      // Port 1 alone, 40 writes with data = addr.
      for (int i = 0; i < 40; i++) drv_q1.push_back(mk(1, 16'(i), 1, 32'(i)));
      run_idle(200);

      // Port 0 releases after 3 reads while port 1 waits.
      for (int i = 0; i < 3; i++) drv_q0.push_back(mk(1, 16'(i), 0, '0));
      for (int i = 0; i < 8; i++) drv_q1.push_back(mk(1, 16'(i + 8), 0, '0));
      run_idle(100);

      // Reset on the 5th access of a port 1 read burst.
      for (int i = 0; i < 10; i++) drv_q1.push_back(mk(1, 16'(i + 20), 0, '0));
      base  = acc_cnt1;
      guard = 0;
      while (acc_cnt1 - base < 4 && guard < 100) begin
         step();
         guard++;
      end
      check("burst_start", 32'(acc_cnt1 - base), 32'd4);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) drv_q0.push_back(mk(1, 16'(i + 4), 0, '0));
      step();
      rst = 1'b0;
      run_idle(100);

      // Top address written by port 1, read back by port 0.
      drv_q1.push_back(mk(1, 16'hFFFF, 1, 32'hA5A5_0001));
      run_idle(50);
      drv_q0.push_back(mk(1, 16'hFFFF, 0, '0));
      run_idle(50);

      // Random mixed traffic with request gaps on both ports.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 30; i++) begin
            drv_q0.push_back(mk($urandom_range(0, 3) != 0, 16'($urandom_range(0, 31)),
                                1'($urandom_range(0, 1)), $urandom));
            drv_q1.push_back(mk($urandom_range(0, 3) != 0, 16'($urandom_range(0, 31)),
                                1'($urandom_range(0, 1)), $urandom));
         end
         run_idle(2000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
